// File: rtl/note_sequencer_pkg.sv
// Shared widths, note codes, FSM states and the ROM word layout for the note sequencer.
package note_sequencer_pkg;

  localparam int unsigned NOTE_W = 6;
  localparam int unsigned DUR_W  = 10;
  localparam int unsigned WORD_W = NOTE_W + DUR_W;

  // Note codes: 0 is a rest, then chromatic C4..B6.
  localparam logic [NOTE_W-1:0] REST = NOTE_W'(0);
  localparam logic [NOTE_W-1:0] C4  = NOTE_W'(1),  CS4 = NOTE_W'(2),  D4  = NOTE_W'(3);
  localparam logic [NOTE_W-1:0] DS4 = NOTE_W'(4),  E4  = NOTE_W'(5),  F4  = NOTE_W'(6);
  localparam logic [NOTE_W-1:0] FS4 = NOTE_W'(7),  G4  = NOTE_W'(8),  GS4 = NOTE_W'(9);
  localparam logic [NOTE_W-1:0] A4  = NOTE_W'(10), AS4 = NOTE_W'(11), B4  = NOTE_W'(12);
  localparam logic [NOTE_W-1:0] C5  = NOTE_W'(13), CS5 = NOTE_W'(14), D5  = NOTE_W'(15);
  localparam logic [NOTE_W-1:0] DS5 = NOTE_W'(16), E5  = NOTE_W'(17), F5  = NOTE_W'(18);
  localparam logic [NOTE_W-1:0] FS5 = NOTE_W'(19), G5  = NOTE_W'(20), GS5 = NOTE_W'(21);
  localparam logic [NOTE_W-1:0] A5  = NOTE_W'(22), AS5 = NOTE_W'(23), B5  = NOTE_W'(24);
  localparam logic [NOTE_W-1:0] C6  = NOTE_W'(25), CS6 = NOTE_W'(26), D6  = NOTE_W'(27);
  localparam logic [NOTE_W-1:0] DS6 = NOTE_W'(28), E6  = NOTE_W'(29), F6  = NOTE_W'(30);
  localparam logic [NOTE_W-1:0] FS6 = NOTE_W'(31), G6  = NOTE_W'(32), GS6 = NOTE_W'(33);
  localparam logic [NOTE_W-1:0] A6  = NOTE_W'(34), AS6 = NOTE_W'(35), B6  = NOTE_W'(36);

  // A zero duration marks the end of the song.
  localparam logic [DUR_W-1:0] END_MARK = '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_END   = 3'd4
  } state_e;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } melody_word_t;

  // Builds one ROM word from a note code and a duration in ticks.
  function automatic melody_word_t mk_word(input logic [NOTE_W-1:0] n,
                                           input logic [DUR_W-1:0]  d);
    melody_word_t w;
    w.note = n;
    w.dur  = d;
    return w;
  endfunction

endpackage

// File: rtl/note_sequencer_rom.sv
// Melody ROM with a one-clock synchronous read; contents come from a packed image
// where word i occupies bits [i*W +: W].
module note_sequencer_rom #(
  parameter int unsigned       DEPTH = 64,
  parameter int unsigned       AW    = 6,
  parameter int unsigned       W     = 16,
  parameter logic [DEPTH*W-1:0] IMAGE = '0
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  output logic [W-1:0]  data_o
);

  logic [W-1:0] words [DEPTH];

  // Unpack the image into addressable words.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign words[i] = IMAGE[i*W +: W];
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    data_o <= words[addr_i];
  end

endmodule

// File: rtl/note_sequencer.sv
// Walks the melody ROM and presents the current note, its valid level and a
// per-word strobe to the downstream tone generator.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int unsigned                  CLK_HZ    = 12_000_000,
  parameter int unsigned                  TICK_HZ   = 1000,
  parameter int unsigned                  ROM_DEPTH = 64,
  parameter int unsigned                  GAP_TICKS = 1,
  parameter logic [ROM_DEPTH*WORD_W-1:0]  ROM_IMAGE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [NOTE_W-1:0] note,
  output logic              note_valid,
  output logic              note_strobe,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned AW  = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [AW-1:0]    LAST_ADDR = AW'(ROM_DEPTH - 1);
  localparam logic [PW-1:0]    PRE_LAST  = PW'(DIV - 1);
  localparam logic [DUR_W-1:0] GAP_CNT   = DUR_W'(GAP_TICKS);
  localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);

  state_e            state_q;
  logic [AW-1:0]     addr_q;
  logic [PW-1:0]     pre_q;
  logic [DUR_W-1:0]  dur_q;
  logic [NOTE_W-1:0] note_q;
  logic              valid_q;
  logic              strobe_q;
  logic              busy_q;
  logic              done_q;
  melody_word_t      rom_word;

  note_sequencer_rom #(
    .DEPTH (ROM_DEPTH),
    .AW    (AW),
    .W     (WORD_W),
    .IMAGE (ROM_IMAGE)
  ) u_rom (
    .clk    (clk),
    .addr_i (addr_q),
    .data_o (rom_word)
  );

  // Sequencer FSM with tick prescaler, duration counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      pre_q    <= '0;
      dur_q    <= '0;
      note_q   <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      if (stop) begin
        state_q <= S_IDLE;
        addr_q  <= '0;
        pre_q   <= '0;
        dur_q   <= '0;
        note_q  <= '0;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q <= S_FETCH;
              addr_q  <= '0;
              busy_q  <= 1'b1;
            end
          end
          S_FETCH: state_q <= S_LOAD;
          S_LOAD: begin
            if (rom_word.dur == END_MARK) begin
              state_q <= S_END;
            end else begin
              note_q   <= rom_word.note;
              dur_q    <= rom_word.dur;
              pre_q    <= '0;
              strobe_q <= 1'b1;
              valid_q  <= (rom_word.note != REST);
              state_q  <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (pre_q == PRE_LAST) begin
              pre_q <= '0;
              dur_q <= dur_q - DUR_ONE;
              if (dur_q == DUR_ONE) begin
                // Last tick of this word: silence and move on (or wrap at the ROM end).
                valid_q <= 1'b0;
                if (addr_q == LAST_ADDR) begin
                  state_q <= S_END;
                end else begin
                  addr_q  <= addr_q + AW'(1);
                  state_q <= S_FETCH;
                end
              end else if ((dur_q - DUR_ONE) == GAP_CNT) begin
                // Articulation gap before the next note.
                valid_q <= 1'b0;
              end
            end else begin
              pre_q <= pre_q + PW'(1);
            end
          end
          S_END: begin
            if (loop_en) begin
              addr_q  <= '0;
              state_q <= S_FETCH;
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              note_q  <= '0;
              state_q <= S_IDLE;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign note        = note_q;
  assign note_valid  = valid_q;
  assign note_strobe = strobe_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: two instances (short song with end marker, full ROM
// without marker) checked cycle by cycle against a song-rendering reference model.
module tb_note_sequencer;
  import note_sequencer_pkg::*;

  localparam int unsigned CLK_HZ  = 1000;
  localparam int unsigned TICK_HZ = 100;
  localparam int          DIV     = 10;
  localparam int          GAP     = 1;
  localparam int          DEPTH   = 64;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic              valid;
    logic              strobe;
    logic              busy;
    logic              done;
  } obs_t;

  typedef struct packed {
    logic is_end;
    obs_t o;
  } frame_t;

  // Song 0: {A4,3},{rest,2},{C5,1},{end}. Song 1: 64 x {B4,1}, no marker.
  function automatic logic [NOTE_W-1:0] w_note(int d, int a);
    if (d == 1) return B4;
    case (a)
      0:       return A4;
      2:       return C5;
      default: return REST;
    endcase
  endfunction

  function automatic int w_dur(int d, int a);
    if (d == 1) return 1;
    case (a)
      0:       return 3;
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [DEPTH*WORD_W-1:0] image(int d);
    logic [DEPTH*WORD_W-1:0] img;
    img = '0;
    for (int a = 0; a < DEPTH; a++)
      img[a*WORD_W +: WORD_W] = mk_word(w_note(d, a), DUR_W'(w_dur(d, a)));
    return img;
  endfunction

  localparam logic [DEPTH*WORD_W-1:0] IMG_S = image(0);
  localparam logic [DEPTH*WORD_W-1:0] IMG_F = image(1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [NOTE_W-1:0] note_s, note_f;
  logic nv_s, st_s, busy_s, done_s;
  logic nv_f, st_f, busy_f, done_f;

  always #5 clk = ~clk;

  note_sequencer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .ROM_DEPTH(DEPTH),
                   .GAP_TICKS(GAP), .ROM_IMAGE(IMG_S)) dut_s (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .note(note_s), .note_valid(nv_s), .note_strobe(st_s), .busy(busy_s), .done(done_s));

  note_sequencer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .ROM_DEPTH(DEPTH),
                   .GAP_TICKS(GAP), .ROM_IMAGE(IMG_F)) dut_f (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .note(note_f), .note_valid(nv_f), .note_strobe(st_f), .busy(busy_f), .done(done_f));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  // Reference model: one expected output frame per clock, rendered from the song.
  frame_t fq [2][$];
  frame_t cur [2];

  // Statistics gathered from the song instance (and the full-ROM instance).
  int st_t[$];
  logic [NOTE_W-1:0] st_n[$];
  int v_a4, v_c5, dn_s, dn_s_t, idle_s, st_f_cnt, dn_f, dn_f_t;

  function automatic void render_pass(int d, logic [NOTE_W-1:0] prev_in);
    logic [NOTE_W-1:0] prev;
    frame_t f;
    prev = prev_in;
    for (int a = 0; a < DEPTH; a++) begin
      logic [NOTE_W-1:0] n;
      int du, vlen;
      n  = w_note(d, a);
      du = w_dur(d, a);
      f = '0;
      f.o.note = prev;
      f.o.busy = 1'b1;
      fq[d].push_back(f);  // address presented
      fq[d].push_back(f);  // word arrives
      if (du == 0) break;
      vlen = (du > GAP) ? (du - GAP) * DIV : du * DIV;
      for (int j = 0; j < du * DIV; j++) begin
        f = '0;
        f.o.note   = n;
        f.o.busy   = 1'b1;
        f.o.strobe = (j == 0);
        f.o.valid  = (n != REST) && (j < vlen);
        fq[d].push_back(f);
      end
      prev = n;
    end
    f = '0;
    f.o.note = prev;
    f.o.busy = 1'b1;
    f.is_end = 1'b1;
    fq[d].push_back(f);
  endfunction

  // Advance the model across one clock edge using the inputs that edge will sample.
  function automatic void model_edge(int d);
    frame_t f;
    if (rst || stop) begin
      fq[d].delete();
      cur[d] = '0;
      return;
    end
    if (!cur[d].o.busy && start) begin
      render_pass(d, '0);
    end else if (cur[d].is_end) begin
      if (loop_en) begin
        render_pass(d, cur[d].o.note);
      end else begin
        f = '0;
        f.o.done = 1'b1;
        fq[d].push_back(f);
      end
    end
    cur[d] = (fq[d].size() > 0) ? fq[d].pop_front() : frame_t'('0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_frame(input string tag, input obs_t obs, input obs_t expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc %0d: observed {note,valid,strobe,busy,done}=%h expected %h",
             tag, cyc, obs, expv);
    end
  endtask

  function automatic obs_t obs_song();
    obs_t o;
    o.note = note_s; o.valid = nv_s; o.strobe = st_s; o.busy = busy_s; o.done = done_s;
    return o;
  endfunction

  function automatic obs_t obs_full();
    obs_t o;
    o.note = note_f; o.valid = nv_f; o.strobe = st_f; o.busy = busy_f; o.done = done_f;
    return o;
  endfunction

  task automatic clear_stats();
    st_t.delete();
    st_n.delete();
    v_a4 = 0; v_c5 = 0; dn_s = 0; dn_s_t = -1; idle_s = 0;
    st_f_cnt = 0; dn_f = 0; dn_f_t = -1;
  endtask

  function automatic int st_time(int i);
    return (st_t.size() > i) ? st_t[i] : -1;
  endfunction

  function automatic int st_note(int i);
    return (st_n.size() > i) ? int'(st_n[i]) : -1;
  endfunction

  // One clock: model update, edge, sample #1 later, compare and collect stats.
  task automatic step();
    for (int d = 0; d < 2; d++) model_edge(d);
    @(posedge clk);
    #1;
    cyc++;
    chk_frame("frame_song", obs_song(), cur[0].o);
    chk_frame("frame_full", obs_full(), cur[1].o);
    if (st_s) begin
      st_t.push_back(cyc - start_cyc);
      st_n.push_back(note_s);
    end
    if (nv_s && note_s == A4) v_a4++;
    if (nv_s && note_s == C5) v_c5++;
    if (done_s) begin dn_s++; dn_s_t = cyc - start_cyc; end
    if (!busy_s) idle_s++;
    if (st_f) st_f_cnt++;
    if (done_f) begin dn_f++; dn_f_t = cyc - start_cyc; end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_start();
    clear_stats();
    start = 1'b1;
    step();
    start_cyc = cyc;
    start = 1'b0;
  endtask

  initial begin
    cur[0] = '0;
    cur[1] = '0;
    clear_stats();

    // Reset state.
    #1;
    chk_frame("reset_song", obs_song(), '0);
    chk_frame("reset_full", obs_full(), '0);
    run(3);
    rst = 1'b0;
    run(2);

    // Plain playback of both songs.
    loop_en = 1'b0;
    pulse_start();
    run(780);
    chk("song_strobe_count", st_t.size(), 3);
    chk("song_strobe0_time", st_time(0), 2);
    chk("song_strobe0_note", st_note(0), A4);
    chk("song_strobe1_time", st_time(1), 2 + 3*DIV + 2);
    chk("song_strobe1_note", st_note(1), REST);
    chk("song_strobe2_time", st_time(2), 2 + 3*DIV + 2 + 2*DIV + 2);
    chk("song_strobe2_note", st_note(2), C5);
    chk("a4_valid_clks", v_a4, 20);
    chk("c5_valid_clks", v_c5, 10);
    chk("song_done_count", dn_s, 1);
    chk("song_done_time", dn_s_t, 69);
    chk("full_strobe_count", st_f_cnt, 64);
    chk("full_done_count", dn_f, 1);
    chk("full_done_time", dn_f_t, 2 + 64*(DIV + 2) - 2 + 1);

    // Looping, with a start re-pulse mid-song that must be ignored.
    loop_en = 1'b1;
    pulse_start();
    run(39);
    start = 1'b1;
    step();
    start = 1'b0;
    run(110);
    chk("loop_strobe3_time", st_time(3), 71);
    chk("loop_strobe3_note", st_note(3), A4);
    chk("loop_strobe1_time", st_time(1), 34);
    chk("loop_done_count", dn_s, 0);
    chk("loop_busy_low_clks", idle_s, 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_frame("stop_loop_song", obs_song(), '0);
    chk_frame("stop_loop_full", obs_full(), '0);
    loop_en = 1'b0;
    run(3);

    // Stop five clocks into the first note.
    pulse_start();
    run(6);
    chk("pre_stop_note", note_s, A4);
    chk("pre_stop_valid", nv_s, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_frame("stop_mid_note", obs_song(), '0);
    run(20);
    chk("stop_no_done", dn_s, 0);

    // start and stop together in IDLE.
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk("start_stop_busy", busy_s, 0);
    run(3);

    // Randomized control traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      loop_en = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 29) == 0);
      stop = ($urandom_range(0, 399) == 0);
      step();
    end
    start = 1'b0;
    loop_en = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    run(2);

    // Asynchronous reset in the middle of a note.
    pulse_start();
    run(8);
    chk("pre_rst_busy", busy_s, 1);
    chk("pre_rst_valid", nv_s, 1);
    #3;
    rst = 1'b1;
    #1;
    chk_frame("async_rst_song", obs_song(), '0);
    chk_frame("async_rst_full", obs_full(), '0);
    run(2);
    rst = 1'b0;
    run(2);

    // Restart after reset replays from the top.
    pulse_start();
    run(40);
    chk("restart_strobe0_time", st_time(0), 2);
    chk("restart_strobe0_note", st_note(0), A4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
